// File: rtl/serial_word_shifter.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word and emits it LSB-first with a
// one-cycle complementer clear before each word. Define SER_B2B_EN for back-to-back words.
module serial_word_shifter #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_bit,
   output logic             bit_valid,
   output logic             frame_clr,
   output logic [CW-1:0]    bit_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             ser_bit_q, ser_bit_d;
   logic             bit_valid_q, bit_valid_d;
   logic             frame_clr_q, frame_clr_d;
   logic             busy_q, busy_d;
   logic             last_bit;
   logic             accept;

   assign last_bit = (state_q == SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));

`ifdef SER_B2B_EN
   assign load_ready = (state_q == IDLE) || last_bit;
`else
   assign load_ready = (state_q == IDLE);
`endif

   assign accept = load_valid && load_ready;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (accept) begin
               shreg_d = load_data;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (last_bit) begin
               bit_cnt_d = '0;
               // accept can only be true here when back-to-back is enabled
               if (accept) begin
                  shreg_d = load_data;
                  state_d = CLEAR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   // Outputs are registered copies of the next-state view so nothing is combinational from inputs
   always_comb begin
      ser_bit_d   = (state_d == SHIFT) && shreg_d[0];
      bit_valid_d = (state_d == SHIFT);
      frame_clr_d = (state_d != SHIFT);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge t_clk or negedge r) begin
      if (!r) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         ser_bit_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         frame_clr_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         ser_bit_q   <= ser_bit_d;
         bit_valid_q <= bit_valid_d;
         frame_clr_q <= frame_clr_d;
         busy_q      <= busy_d;
      end
   end

   assign ser_bit   = ser_bit_q;
   assign bit_valid = bit_valid_q;
   assign frame_clr = frame_clr_q;
   assign bit_cnt   = bit_cnt_q;
   assign busy      = busy_q;

endmodule
